// File: rtl/booth_mult_24b.sv
// Sequential radix-2 Booth multiplier, 24x24 unsigned -> 48-bit product.
// Add/subtract steps are delegated to an external 25-bit adder over REQ/ACK.
module booth_mult_24b (
  input  logic        CLK,
  input  logic        RSTK,
  input  logic [23:0] m1,
  input  logic [23:0] m2,
  input  logic        BREQ,
  output logic        BACK,
  output logic [47:0] res,
  output logic [24:0] Adder_datain1,
  output logic [24:0] Adder_datain2,
  output logic        Adder_valid,
  input  logic [24:0] Adder_dataout,
  input  logic        Adder_carryout,
  input  logic        Adder_ack,
  input  logic [2:0]  Adder_Exc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXAM,
    S_ADD,
    S_ARLS,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [24:0] r_m;
  logic [24:0] r_a;
  logic [24:0] r_q;
  logic        r_q1;
  logic [4:0]  r_cnt;

  logic [24:0] w_neg_m;
  logic [49:0] w_prod;
  logic        w_add;
  logic        w_sub;
  logic        w_unused;

  assign w_neg_m  = ~r_m + 25'd1;
  assign w_prod   = {r_a, r_q};
  assign w_add    = ({r_q[0], r_q1} == 2'b01);
  assign w_sub    = ({r_q[0], r_q1} == 2'b10);
  // Carry and exception are meaningless in mod 2^25 accumulation.
  assign w_unused = ^{Adder_carryout, Adder_Exc};

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      r_state       <= S_IDLE;
      r_m           <= '0;
      r_a           <= '0;
      r_q           <= '0;
      r_q1          <= 1'b0;
      r_cnt         <= '0;
      BACK          <= 1'b0;
      res           <= '0;
      Adder_datain1 <= '0;
      Adder_datain2 <= '0;
      Adder_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (BREQ && !BACK) begin
            r_m     <= {1'b0, m1};
            r_q     <= {1'b0, m2};
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= 5'd25;
            r_state <= S_EXAM;
          end
        end
        S_EXAM: begin
          unique case (1'b1)
            w_add: begin
              Adder_datain1 <= r_a;
              Adder_datain2 <= r_m;
              Adder_valid   <= 1'b1;
              r_state       <= S_ADD;
            end
            w_sub: begin
              Adder_datain1 <= r_a;
              Adder_datain2 <= w_neg_m;
              Adder_valid   <= 1'b1;
              r_state       <= S_ADD;
            end
            default: r_state <= S_SHIFT;
          endcase
        end
        S_ADD: begin
          if (Adder_ack) begin
            r_a         <= Adder_dataout;
            Adder_valid <= 1'b0;
            r_state     <= S_ARLS;
          end
        end
        S_ARLS: begin
          if (!Adder_ack) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_a   <= {r_a[24], r_a[24:1]};
          r_q   <= {r_a[0], r_q[24:1]};
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_state <= S_DONE;
          else               r_state <= S_EXAM;
        end
        S_DONE: begin
          // Result is captured once; BACK then waits for BREQ to drop.
          if (!BACK) begin
            res  <= w_prod[47:0];
            BACK <= 1'b1;
          end else if (!BREQ) begin
            BACK    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_24b.sv
// Directed self-checking bench for booth_mult_24b with a behavioural
// 4-phase adder partner whose ack delay is programmable.
module tb_booth_mult_24b;

  logic        CLK = 1'b0;
  logic        RSTK = 1'b1;
  logic [23:0] m1 = '0;
  logic [23:0] m2 = '0;
  logic        BREQ = 1'b0;
  logic        BACK;
  logic [47:0] res;
  logic [24:0] Adder_datain1;
  logic [24:0] Adder_datain2;
  logic        Adder_valid;
  logic [24:0] Adder_dataout;
  logic        Adder_carryout;
  logic        Adder_ack;
  logic [2:0]  Adder_Exc = 3'b000;

  int checks = 0;
  int errors = 0;
  int add_delay = 0;
  int dcnt = 0;
  int lat;
  bit chk_stable = 1'b0;
  logic [24:0] cap1, cap2;
  bit capv = 1'b0;

  booth_mult_24b dut (
    .CLK(CLK),
    .RSTK(RSTK),
    .m1(m1),
    .m2(m2),
    .BREQ(BREQ),
    .BACK(BACK),
    .res(res),
    .Adder_datain1(Adder_datain1),
    .Adder_datain2(Adder_datain2),
    .Adder_valid(Adder_valid),
    .Adder_dataout(Adder_dataout),
    .Adder_carryout(Adder_carryout),
    .Adder_ack(Adder_ack),
    .Adder_Exc(Adder_Exc)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      Adder_ack      <= 1'b0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
      dcnt           <= 0;
    end else if (Adder_valid && !Adder_ack) begin
      if (dcnt >= add_delay) begin
        {Adder_carryout, Adder_dataout} <=
          {1'b0, Adder_datain1} + {1'b0, Adder_datain2};
        Adder_ack <= 1'b1;
        dcnt      <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else if (!Adder_valid) begin
      Adder_ack <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_stable && Adder_valid && !RSTK) begin
      if (capv) begin
        checks++;
        assert ({Adder_datain1, Adder_datain2} === {cap1, cap2}) else begin
          errors++;
          $error("FAIL operand_stable: observed %h_%h expected %h_%h",
                 Adder_datain1, Adder_datain2, cap1, cap2);
        end
      end
      cap1 = Adder_datain1;
      cap2 = Adder_datain2;
      capv = 1'b1;
    end else begin
      capv = 1'b0;
    end
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp,
                     input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_back(output int n);
    n = 0;
    while (BACK !== 1'b1 && n < 3000) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] exp, input string tag,
                        output int n);
    int k;
    @(negedge CLK);
    m1   = a;
    m2   = b;
    BREQ = 1'b1;
    wait_back(n);
    chk({63'd0, BACK}, 64'd1, {tag, "_back_rise"});
    chk({16'd0, res}, {16'd0, exp}, {tag, "_res"});
    @(negedge CLK);
    BREQ = 1'b0;
    k = 0;
    while (BACK !== 1'b0 && k < 10) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk({63'd0, BACK}, 64'd0, {tag, "_back_fall"});
  endtask

  task automatic chk_reset(input string tag);
    chk({16'd0, res}, 64'd0, {tag, "_res"});
    chk({63'd0, BACK}, 64'd0, {tag, "_back"});
    chk({63'd0, Adder_valid}, 64'd0, {tag, "_valid"});
    chk({14'd0, Adder_datain1, Adder_datain2}, 64'd0, {tag, "_din"});
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_reset("reset");
    @(negedge CLK);
    RSTK = 1'b0;

    run_op(24'hA00000, 24'hE00000, 48'h8C0000000000, "t1", lat);
    run_op(24'h000001, 24'h00FFFF, 48'h00000000FFFF, "t2", lat);

    run_op(24'h123456, 24'h000000, 48'h0, "lat_noadd", lat);
    chk(64'(lat), 64'd52, "latency_min");

    @(negedge CLK);
    RSTK = 1'b1;
    @(negedge CLK);
    RSTK = 1'b0;
    run_op(24'h000001, 24'h00FFFF, 48'h00000000FFFF, "t3", lat);

    run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "t4_max", lat);
    run_op(24'h000000, 24'h123456, 48'h0, "t4_zero", lat);
    run_op(24'h800000, 24'h000002, 48'h000001000000, "msb_x2", lat);
    run_op(24'h123456, 24'h000010, 48'h000001234560, "x16", lat);

    @(negedge CLK);
    m1   = 24'h000007;
    m2   = 24'h000009;
    BREQ = 1'b1;
    repeat (3) @(negedge CLK);
    BREQ = 1'b0;
    wait_back(lat);
    chk({63'd0, BACK}, 64'd1, "early_drop_back");
    chk({16'd0, res}, 64'd63, "early_drop_res");
    @(posedge CLK);
    #1;
    chk({63'd0, BACK}, 64'd0, "early_drop_pulse");

    @(negedge CLK);
    m1   = 24'hA00000;
    m2   = 24'hE00000;
    BREQ = 1'b1;
    repeat (25) @(negedge CLK);
    #2;
    RSTK = 1'b1;
    #1;
    chk_reset("t5_async");
    BREQ = 1'b0;
    @(negedge CLK);
    RSTK = 1'b0;
    run_op(24'h000003, 24'h000005, 48'd15, "t5_after", lat);

    add_delay  = 3;
    chk_stable = 1'b1;
    run_op(24'hA00000, 24'hE00000, 48'h8C0000000000, "t6_t1", lat);
    run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "t6_max", lat);
    chk_stable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
